// File: rtl/ad9361_ctrl_pkg.sv
// Shared types, default timing constants and counter sizing for the AD9361 control sequencer.
package ad9361_ctrl_pkg;

   typedef enum logic [1:0] {
      S_RESET,
      S_SETTLE,
      S_READY
   } seq_state_t;

   localparam int DEF_N_CHAN        = 2;
   localparam int DEF_RESET_CYCLES  = 1000;
   localparam int DEF_SETTLE_CYCLES = 5000;
   localparam int DEF_SYNC_CYCLES   = 4;
   localparam int DEF_PULSE_CYCLES  = 2;

   // Bits needed for a down-counter that must hold the larger of two load values.
   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/ad9361_ensm_ch.sv
// One channel of ENSM ENABLE/TXNRX drive: level pass-through or edge-triggered fixed-width pulse.
module ad9361_ensm_ch
   import ad9361_ctrl_pkg::*;
#(
   parameter int PULSE_CYCLES = DEF_PULSE_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic pulse_mode,
   input  logic gate,
   input  logic enable_req,
   input  logic txnrx_req,
   output logic enable,
   output logic txnrx
);

   localparam int PCNT_W = cnt_width(PULSE_CYCLES, 1);

   logic [PCNT_W-1:0] pcnt_reg, pcnt_next;
   logic              prev_reg;
   logic              hold_reg, hold_next;
   logic              enable_reg, enable_next;
   logic              txnrx_reg, txnrx_next;
   logic              edge_ok;

   always_ff @(posedge clk) begin
      if (rst) begin
         pcnt_reg   <= '0;
         prev_reg   <= 1'b0;
         hold_reg   <= 1'b0;
         enable_reg <= 1'b0;
         txnrx_reg  <= 1'b0;
      end else begin
         pcnt_reg   <= pcnt_next;
         prev_reg   <= enable_req;
         hold_reg   <= hold_next;
         enable_reg <= enable_next;
         txnrx_reg  <= txnrx_next;
      end
   end

   always_comb begin
      pcnt_next   = pcnt_reg;
      hold_next   = hold_reg;
      enable_next = 1'b0;
      txnrx_next  = 1'b0;
      // A rising edge only counts while the channel is live and no pulse is still running.
      edge_ok     = enable_req & ~prev_reg & gate & (pcnt_reg == '0);

      if (!gate) begin
         pcnt_next = '0;
         hold_next = 1'b0;
      end else if (pulse_mode) begin
         if (edge_ok) begin
            pcnt_next = PCNT_W'(PULSE_CYCLES);
            hold_next = txnrx_req;
         end else if (pcnt_reg != '0) begin
            pcnt_next = pcnt_reg - PCNT_W'(1);
         end
         enable_next = (pcnt_next != '0);
         txnrx_next  = hold_next;
      end else begin
         enable_next = enable_req;
         txnrx_next  = txnrx_req;
      end
   end

   assign enable = enable_reg;
   assign txnrx  = txnrx_reg;

endmodule

// File: rtl/ad9361_ctrl_seq.sv
// Clocked control-pin sequencer for N_CHAN AD9361 devices: RESETB sequencing, multi-chip SYNC,
// ENSM ENABLE/TXNRX and EN_AGC, all from registered outputs.
module ad9361_ctrl_seq
   import ad9361_ctrl_pkg::*;
#(
   parameter int N_CHAN        = DEF_N_CHAN,
   parameter int RESET_CYCLES  = DEF_RESET_CYCLES,
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   parameter int SYNC_CYCLES   = DEF_SYNC_CYCLES,
   parameter int PULSE_CYCLES  = DEF_PULSE_CYCLES
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              reset_req,
   input  logic [N_CHAN-1:0] chan_mask,
   input  logic              sync_req,
   input  logic              ensm_pulse_mode,
   input  logic [N_CHAN-1:0] ensm_enable_req,
   input  logic [N_CHAN-1:0] ensm_txnrx_req,
   input  logic [N_CHAN-1:0] agc_en_req,
   output logic [N_CHAN-1:0] enable,
   output logic [N_CHAN-1:0] txnrx,
   output logic [N_CHAN-1:0] resetb,
   output logic [N_CHAN-1:0] sync,
   output logic [N_CHAN-1:0] en_agc,
   output logic              ready,
   output logic              busy
);

   localparam int CNT_W  = cnt_width(RESET_CYCLES, SETTLE_CYCLES);
   localparam int SYNC_W = cnt_width(SYNC_CYCLES, 1);

   seq_state_t        state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [SYNC_W-1:0] sync_cnt_reg, sync_cnt_next;
   logic [N_CHAN-1:0] mask_reg, mask_next;
   logic [N_CHAN-1:0] resetb_reg, resetb_next;
   logic [N_CHAN-1:0] en_agc_reg, en_agc_next;
   logic [N_CHAN-1:0] ch_gate;
   logic              ready_reg, ready_next;
   logic              busy_reg, busy_next;
   logic              sync_reg, sync_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= S_RESET;
         cnt_reg      <= CNT_W'(RESET_CYCLES);
         sync_cnt_reg <= '0;
         mask_reg     <= '1;
         resetb_reg   <= '0;
         en_agc_reg   <= '0;
         ready_reg    <= 1'b0;
         busy_reg     <= 1'b1;
         sync_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         sync_cnt_reg <= sync_cnt_next;
         mask_reg     <= mask_next;
         resetb_reg   <= resetb_next;
         en_agc_reg   <= en_agc_next;
         ready_reg    <= ready_next;
         busy_reg     <= busy_next;
         sync_reg     <= sync_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      mask_next     = mask_reg;
      resetb_next   = resetb_reg;
      sync_cnt_next = sync_cnt_reg;
      if (sync_cnt_reg != '0)
         sync_cnt_next = sync_cnt_reg - SYNC_W'(1);

      case (state_reg)
         S_RESET: begin
            resetb_next = resetb_reg & ~mask_reg;
            if (cnt_reg == CNT_W'(1)) begin
               state_next  = S_SETTLE;
               cnt_next    = CNT_W'(SETTLE_CYCLES);
               resetb_next = '1;
            end else begin
               cnt_next = cnt_reg - CNT_W'(1);
            end
         end
         S_SETTLE: begin
            if (cnt_reg == CNT_W'(1))
               state_next = S_READY;
            else
               cnt_next = cnt_reg - CNT_W'(1);
         end
         S_READY: begin
            // Reset takes priority and also kills any SYNC pulse in flight.
            if (reset_req && (chan_mask != '0)) begin
               state_next    = S_RESET;
               cnt_next      = CNT_W'(RESET_CYCLES);
               mask_next     = chan_mask;
               resetb_next   = resetb_reg & ~chan_mask;
               sync_cnt_next = '0;
            end else if (sync_req && (sync_cnt_reg == '0)) begin
               sync_cnt_next = SYNC_W'(SYNC_CYCLES);
            end
         end
         default: begin
            state_next = S_RESET;
            cnt_next   = CNT_W'(RESET_CYCLES);
            mask_next  = '1;
         end
      endcase

      ready_next  = (state_next == S_READY);
      sync_next   = (sync_cnt_next != '0);
      busy_next   = !ready_next || sync_next;
      // Channel drive drops with ready immediately but resumes only after a full ready cycle.
      ch_gate     = {N_CHAN{ready_reg & ready_next}} & resetb_next;
      en_agc_next = agc_en_req & ch_gate;
   end

   for (genvar gi = 0; gi < N_CHAN; gi++) begin : g_ch
      ad9361_ensm_ch #(
         .PULSE_CYCLES(PULSE_CYCLES)
      ) u_ensm (
         .clk        (clk),
         .rst        (rst),
         .pulse_mode (ensm_pulse_mode),
         .gate       (ch_gate[gi]),
         .enable_req (ensm_enable_req[gi]),
         .txnrx_req  (ensm_txnrx_req[gi]),
         .enable     (enable[gi]),
         .txnrx      (txnrx[gi])
      );
   end

   assign resetb = resetb_reg;
   assign sync   = {N_CHAN{sync_reg}};
   assign en_agc = en_agc_reg;
   assign ready  = ready_reg;
   assign busy   = busy_reg;

endmodule

// File: tb/tb_ad9361_ctrl_seq.sv
// Table-driven bench for ad9361_ctrl_seq: each row drives inputs for n cycles and queues the
// outputs expected after the following clock edge.
module tb_ad9361_ctrl_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       reset_req;
   logic [1:0] chan_mask;
   logic       sync_req;
   logic       ensm_pulse_mode;
   logic [1:0] ensm_enable_req;
   logic [1:0] ensm_txnrx_req;
   logic [1:0] agc_en_req;
   logic [1:0] enable, txnrx, resetb, sync, en_agc;
   logic       ready, busy;

   ad9361_ctrl_seq #(
      .N_CHAN(2), .RESET_CYCLES(4), .SETTLE_CYCLES(6), .SYNC_CYCLES(4), .PULSE_CYCLES(2)
   ) dut (
      .clk(clk), .rst(rst), .reset_req(reset_req), .chan_mask(chan_mask), .sync_req(sync_req),
      .ensm_pulse_mode(ensm_pulse_mode), .ensm_enable_req(ensm_enable_req),
      .ensm_txnrx_req(ensm_txnrx_req), .agc_en_req(agc_en_req), .enable(enable), .txnrx(txnrx),
      .resetb(resetb), .sync(sync), .en_agc(en_agc), .ready(ready), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      int          n;
      logic        rr;
      logic [1:0]  cm;
      logic        sr;
      logic        md;
      logic [1:0]  en;
      logic [1:0]  tx;
      logic [11:0] exp;
   } vec_t;

   typedef struct {
      logic [11:0] exp;
      string       name;
   } sb_t;

   vec_t tbl[$];
   sb_t  sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic logic [11:0] pk(logic [1:0] rb, logic [1:0] en, logic [1:0] tx,
                                      logic [1:0] sy, logic [1:0] ag, logic rdy, logic bsy);
      return {rb, en, tx, sy, ag, rdy, bsy};
   endfunction

   function automatic vec_t V(string name, int n, logic rr, logic [1:0] cm, logic sr, logic md,
                              logic [1:0] en, logic [1:0] tx, logic [11:0] exp);
      vec_t v;
      v.name = name; v.n = n; v.rr = rr; v.cm = cm; v.sr = sr; v.md = md;
      v.en = en; v.tx = tx; v.exp = exp;
      return v;
   endfunction

   task automatic check_out();
      sb_t         e;
      logic [11:0] got;
      got = {resetb, enable, txnrx, sync, en_agc, ready, busy};
      n_cmp++;
      if (sb_q.size() == 0) begin
         n_bad++;
         $display("FAIL scoreboard: no expected entry, dut=%b", got);
         return;
      end
      e = sb_q.pop_front();
      if (got !== e.exp)
         begin
            n_bad++;
            $display("FAIL %s: dut=%b expected=%b [resetb,enable,txnrx,sync,en_agc,ready,busy]",
                     e.name, got, e.exp);
         end
      else
         $display("ok   %s: %b", e.name, got);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; reset_req = 1'b0; chan_mask = 2'b00; sync_req = 1'b0;
      ensm_pulse_mode = 1'b0; ensm_enable_req = 2'b00; ensm_txnrx_req = 2'b00; agc_en_req = 2'b00;

      //            name             n  rr cm     sr md en     tx        rb     en     tx     sy     ag     rdy bsy
      // Power-on sequence, AGC requested throughout settle
      tbl.push_back(V("rst_hold",      3, 0, 2'b00, 0, 0, 2'b00, 2'b00, pk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1)));
      tbl.push_back(V("settle",        6, 0, 2'b00, 0, 0, 2'b00, 2'b00, pk(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1)));
      tbl.push_back(V("ready_rise",    1, 0, 2'b00, 0, 0, 2'b00, 2'b00, pk(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0)));
      tbl.push_back(V("agc_on",        1, 0, 2'b00, 0, 0, 2'b00, 2'b00, pk(2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 1, 0)));
      // Level-mode ENSM
      tbl.push_back(V("lvl_01",        1, 0, 2'b00, 0, 0, 2'b01, 2'b01, pk(2'b11, 2'b01, 2'b01, 2'b00, 2'b11, 1, 0)));
      tbl.push_back(V("lvl_00",        1, 0, 2'b00, 0, 0, 2'b00, 2'b00, pk(2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 1, 0)));
      tbl.push_back(V("lvl_10",        1, 0, 2'b00, 0, 0, 2'b10, 2'b00, pk(2'b11, 2'b10, 2'b00, 2'b00, 2'b11, 1, 0)));
      tbl.push_back(V("lvl_11",        1, 0, 2'b00, 0, 0, 2'b11, 2'b10, pk(2'b11, 2'b11, 2'b10, 2'b00, 2'b11, 1, 0)));
      tbl.push_back(V("lvl_hold",      1, 0, 2'b00, 0, 0, 2'b01, 2'b00, pk(2'b11, 2'b01, 2'b00, 2'b00, 2'b11, 1, 0)));
      // Partial reset of channel 1
      tbl.push_back(V("prst_req",      1, 1, 2'b10, 0, 0, 2'b01, 2'b00, pk(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1)));
      tbl.push_back(V("prst_low",      3, 0, 2'b00, 0, 0, 2'b01, 2'b00, pk(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1)));
      tbl.push_back(V("prst_settle",   6, 0, 2'b00, 0, 0, 2'b01, 2'b00, pk(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1)));
      tbl.push_back(V("prst_ready",    1, 0, 2'b00, 0, 0, 2'b01, 2'b00, pk(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0)));
      tbl.push_back(V("prst_ensm",     1, 0, 2'b00, 0, 0, 2'b01, 2'b00, pk(2'b11, 2'b01, 2'b00, 2'b00, 2'b11, 1, 0)));
      // SYNC pulse, retrigger attempt mid-pulse
      tbl.push_back(V("sync_start",    1, 0, 2'b00, 1, 0, 2'b01, 2'b00, pk(2'b11, 2'b01, 2'b00, 2'b11, 2'b11, 1, 1)));
      tbl.push_back(V("sync_on",       1, 0, 2'b00, 0, 0, 2'b01, 2'b00, pk(2'b11, 2'b01, 2'b00, 2'b11, 2'b11, 1, 1)));
      tbl.push_back(V("sync_retrig",   1, 0, 2'b00, 1, 0, 2'b01, 2'b00, pk(2'b11, 2'b01, 2'b00, 2'b11, 2'b11, 1, 1)));
      tbl.push_back(V("sync_last",     1, 0, 2'b00, 0, 0, 2'b01, 2'b00, pk(2'b11, 2'b01, 2'b00, 2'b11, 2'b11, 1, 1)));
      tbl.push_back(V("sync_end",      1, 0, 2'b00, 0, 0, 2'b01, 2'b00, pk(2'b11, 2'b01, 2'b00, 2'b00, 2'b11, 1, 0)));
      tbl.push_back(V("sync_no_ext",   1, 0, 2'b00, 0, 0, 2'b01, 2'b00, pk(2'b11, 2'b01, 2'b00, 2'b00, 2'b11, 1, 0)));
      // Simultaneous reset+sync on ch0; switch to pulse mode while not ready
      tbl.push_back(V("rst_sync_both", 1, 1, 2'b01, 1, 0, 2'b00, 2'b00, pk(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1)));
      tbl.push_back(V("rst2_low",      1, 0, 2'b00, 0, 1, 2'b00, 2'b00, pk(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1)));
      tbl.push_back(V("rst2_rr_ign",   1, 1, 2'b11, 0, 1, 2'b00, 2'b00, pk(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1)));
      tbl.push_back(V("rst2_low_end",  1, 0, 2'b00, 0, 1, 2'b00, 2'b00, pk(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1)));
      tbl.push_back(V("rst2_settle",   1, 0, 2'b00, 0, 1, 2'b00, 2'b00, pk(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1)));
      tbl.push_back(V("edge_notready", 1, 0, 2'b00, 0, 1, 2'b01, 2'b01, pk(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1)));
      tbl.push_back(V("settle_rr_ign", 1, 1, 2'b11, 0, 1, 2'b01, 2'b01, pk(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1)));
      tbl.push_back(V("rst2_settle2",  3, 0, 2'b00, 0, 1, 2'b01, 2'b01, pk(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1)));
      tbl.push_back(V("rst2_ready",    1, 0, 2'b00, 0, 1, 2'b01, 2'b01, pk(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0)));
      tbl.push_back(V("no_late_pulse", 1, 0, 2'b00, 0, 1, 2'b01, 2'b01, pk(2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 1, 0)));
      // Pulse-mode ENSM
      tbl.push_back(V("pulse_idle",    1, 0, 2'b00, 0, 1, 2'b00, 2'b00, pk(2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 1, 0)));
      tbl.push_back(V("pulse_start",   1, 0, 2'b00, 0, 1, 2'b01, 2'b01, pk(2'b11, 2'b01, 2'b01, 2'b00, 2'b11, 1, 0)));
      tbl.push_back(V("pulse_2nd",     1, 0, 2'b00, 0, 1, 2'b00, 2'b00, pk(2'b11, 2'b01, 2'b01, 2'b00, 2'b11, 1, 0)));
      tbl.push_back(V("pulse_midedge", 1, 0, 2'b00, 0, 1, 2'b01, 2'b00, pk(2'b11, 2'b00, 2'b01, 2'b00, 2'b11, 1, 0)));
      tbl.push_back(V("pulse_high",    1, 0, 2'b00, 0, 1, 2'b01, 2'b00, pk(2'b11, 2'b00, 2'b01, 2'b00, 2'b11, 1, 0)));
      tbl.push_back(V("pulse_low",     1, 0, 2'b00, 0, 1, 2'b00, 2'b00, pk(2'b11, 2'b00, 2'b01, 2'b00, 2'b11, 1, 0)));
      tbl.push_back(V("pulse_ch1",     1, 0, 2'b00, 0, 1, 2'b10, 2'b10, pk(2'b11, 2'b10, 2'b11, 2'b00, 2'b11, 1, 0)));
      tbl.push_back(V("pulse_ch1_2nd", 1, 0, 2'b00, 0, 1, 2'b00, 2'b00, pk(2'b11, 2'b10, 2'b11, 2'b00, 2'b11, 1, 0)));
      tbl.push_back(V("pulse_ch1_end", 1, 0, 2'b00, 0, 1, 2'b00, 2'b00, pk(2'b11, 2'b00, 2'b11, 2'b00, 2'b11, 1, 0)));
      // Zero-mask reset ignored; reset cancels a running SYNC pulse
      tbl.push_back(V("rst_mask0",     1, 1, 2'b00, 0, 1, 2'b00, 2'b00, pk(2'b11, 2'b00, 2'b11, 2'b00, 2'b11, 1, 0)));
      tbl.push_back(V("sync_again",    1, 0, 2'b00, 1, 1, 2'b00, 2'b00, pk(2'b11, 2'b00, 2'b11, 2'b11, 2'b11, 1, 1)));
      tbl.push_back(V("rst_kill_sync", 1, 1, 2'b11, 0, 1, 2'b00, 2'b00, pk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1)));
      tbl.push_back(V("rst3_low",      3, 0, 2'b00, 0, 1, 2'b00, 2'b00, pk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1)));
      tbl.push_back(V("rst3_settle",   6, 0, 2'b00, 0, 1, 2'b00, 2'b00, pk(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1)));
      tbl.push_back(V("rst3_ready",    1, 0, 2'b00, 0, 1, 2'b00, 2'b00, pk(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0)));
      tbl.push_back(V("rst3_txn_clr",  1, 0, 2'b00, 0, 1, 2'b00, 2'b00, pk(2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 1, 0)));

      // Hand-written reset phase: three cycles of rst, reset values after each edge
      for (int i = 0; i < 3; i++) begin
         sb_q.push_back('{pk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1), "por"});
         @(posedge clk);
         #1;
         check_out();
      end
      agc_en_req = 2'b11;

      foreach (tbl[k]) begin
         for (int r = 0; r < tbl[k].n; r++) begin
            @(negedge clk);
            rst             = 1'b0;
            reset_req       = tbl[k].rr;
            chan_mask       = tbl[k].cm;
            sync_req        = tbl[k].sr;
            ensm_pulse_mode = tbl[k].md;
            ensm_enable_req = tbl[k].en;
            ensm_txnrx_req  = tbl[k].tx;
            sb_q.push_back('{tbl[k].exp, tbl[k].name});
            @(posedge clk);
            #1;
            check_out();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
